// File: rtl/spi_target_pkg.sv
// spi_target_pkg: shared SD-over-SPI framing constants and frame FSM states
package spi_target_pkg;
   localparam int         SPI_FRAME_BYTES = 6;
   localparam logic [1:0] SD_START_BITS   = 2'b01;
   localparam logic [6:0] CRC7_POLY       = 7'h09;
   typedef enum logic [1:0] {HUNT, COLLECT, DONE} frame_state_e;
endpackage

// File: rtl/spi_target_if.sv
// spi_target_if: SPI pins plus byte/command side of the SD SPI target
interface spi_target_if;
   logic        sclk, mosi, _cs, miso, miso_oe;
   logic [7:0]  rx_data, tx_data;
   logic        rx_valid, tx_load, tx_ready, cmd_valid, cmd_crc_err;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   modport slave (
      input  sclk, mosi, _cs, tx_data, tx_load,
      output miso, miso_oe, rx_data, rx_valid, tx_ready, cmd_index, cmd_arg, cmd_valid, cmd_crc_err
   );
   modport master (
      output sclk, mosi, _cs, tx_data, tx_load,
      input  miso, miso_oe, rx_data, rx_valid, tx_ready, cmd_index, cmd_arg, cmd_valid, cmd_crc_err
   );
endinterface

// File: rtl/spi_crc7.sv
// spi_crc7: serial CRC7 (x^7+x^3+1, init 0) with clear and bit-enable
module spi_crc7
   import spi_target_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);
   always_ff @(posedge clk or posedge rst)
      if (rst) crc <= '0;
      else if (clr) crc <= '0;
      else if (en) crc <= {crc[5:0], 1'b0} ^ ((din ^ crc[6]) ? CRC7_POLY : 7'h00);
endmodule

// File: rtl/spi_target.sv
// spi_target: oversampled SPI mode-0 SD card target with 6-byte command framing
// Define SPI_TARGET_CRC7_CHECK_EN to check the CRC7 of every command frame.
module spi_target
   import spi_target_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
   input logic         clk,
   input logic         reset,
   spi_target_if.slave bus
);
   localparam int N = SYNC_STAGES;
   logic [N-1:0] sclk_s, mosi_s, cs_s;
   logic [2:0]   bit_cnt, byte_cnt;
   logic [6:0]   rx_shift;
   logic [7:0]   rx_data, tx_shift, tx_hold, load_byte;
   logic [5:0]   cmd_index;
   logic [31:0]  cmd_arg;
   logic         rx_valid, tx_full, miso, sel, rise, fall, cs_fall, cs_rise;
   logic         byte_done, start, last, cmd_crc_err;
   frame_state_e state, state_n;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sclk_s <= '0;
         mosi_s <= '0;
         cs_s   <= '1;
      end else begin
         sclk_s <= {sclk_s[N-2:0], bus.sclk};
         mosi_s <= {mosi_s[N-2:0], bus.mosi};
         cs_s   <= {cs_s[N-2:0], bus._cs};
      end

   assign sel       = ~cs_s[N-2];
   assign rise      = sel & sclk_s[N-2] & ~sclk_s[N-1];
   assign fall      = sel & ~sclk_s[N-2] & sclk_s[N-1];
   assign cs_fall   = ~cs_s[N-2] & cs_s[N-1];
   assign cs_rise   = cs_s[N-2] & ~cs_s[N-1];
   assign byte_done = rise & (bit_cnt == 3'd7);
   assign load_byte = tx_full ? tx_hold : IDLE_BYTE;

   // tx_shift keeps the next bit to emit in [7]; the MSB of a fresh byte leaves at _cs fall or the 8th fall
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         bit_cnt  <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_shift <= '1;
         tx_hold  <= '0;
         tx_full  <= 1'b0;
         miso     <= 1'b1;
      end else begin
         rx_valid <= byte_done;
         tx_full  <= (tx_full & ~(cs_fall | byte_done)) | (bus.tx_load & ~tx_full);
         if (bus.tx_load & ~tx_full) tx_hold <= bus.tx_data;
         if (cs_rise) begin
            bit_cnt <= '0;
            miso    <= 1'b1;
         end else if (rise) begin
            rx_shift <= {rx_shift[5:0], mosi_s[N-1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) rx_data <= {rx_shift, mosi_s[N-1]};
         end
         if (cs_fall) begin
            tx_shift <= {load_byte[6:0], 1'b1};
            miso     <= load_byte[7];
         end else if (byte_done) tx_shift <= load_byte;
         else if (fall) begin
            miso     <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b1};
         end
      end

   assign start = rx_valid & (rx_data[7:6] == SD_START_BITS);
   assign last  = rx_valid & (byte_cnt == 3'(SPI_FRAME_BYTES - 1));

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= HUNT;
      else state <= state_n;

   always_comb begin
      state_n = state;
      if (cs_rise) state_n = HUNT;
      else if (state == HUNT) state_n = start ? COLLECT : HUNT;
      else if (state == COLLECT) state_n = last ? DONE : COLLECT;
      else state_n = HUNT;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         byte_cnt  <= '0;
         cmd_index <= '0;
         cmd_arg   <= '0;
      end else if (state == HUNT && state_n == COLLECT) begin
         cmd_index <= rx_data[5:0];
         byte_cnt  <= 3'd1;
      end else if (state == COLLECT && state_n == COLLECT && rx_valid) begin
         cmd_arg  <= {cmd_arg[23:0], rx_data};
         byte_cnt <= byte_cnt + 3'd1;
      end

`ifdef SPI_TARGET_CRC7_CHECK_EN
   logic [7:0] crc_sh;
   logic [3:0] crc_cnt;
   logic [6:0] crc;
   logic       crc_clr, crc_feed;
   // frame bytes 1..5 are replayed bit-serially into the CRC long before byte 6 completes
   assign crc_clr  = state == HUNT && state_n == COLLECT;
   assign crc_feed = crc_clr || (state == COLLECT && state_n == COLLECT && rx_valid);

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         crc_sh      <= '0;
         crc_cnt     <= '0;
         cmd_crc_err <= 1'b0;
      end else begin
         if (crc_feed) begin
            crc_sh  <= rx_data;
            crc_cnt <= 4'd8;
         end else if (crc_cnt != 4'd0) begin
            crc_sh  <= {crc_sh[6:0], 1'b0};
            crc_cnt <= crc_cnt - 4'd1;
         end
         if (state == COLLECT && state_n == DONE) cmd_crc_err <= (rx_data[7:1] != crc) | ~rx_data[0];
      end

   spi_crc7 u_crc (
      .clk (clk),
      .rst (reset),
      .clr (crc_clr),
      .en  (crc_cnt != 4'd0),
      .din (crc_sh[7]),
      .crc (crc)
   );
`else
   assign cmd_crc_err = 1'b0;
`endif

   assign bus.miso        = miso;
   assign bus.miso_oe     = sel;
   assign bus.rx_data     = rx_data;
   assign bus.rx_valid    = rx_valid;
   assign bus.tx_ready    = ~tx_full;
   assign bus.cmd_index   = cmd_index;
   assign bus.cmd_arg     = cmd_arg;
   assign bus.cmd_valid   = state == DONE;
   assign bus.cmd_crc_err = cmd_crc_err;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: directed and randomized checks of spi_target against a byte-stream model
module tb_spi_target;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   spi_target_if bus ();
   spi_target dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef SPI_TARGET_CRC7_CHECK_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   int nvec = 0, nerr = 0, tx_falls = 0;
   logic ready_q = 1'b1;
   logic [7:0]  got_rx[$];
   logic [38:0] got_cmds[$], exp_c[$];
   int          got_at[$], exp_at[$];

   always @(negedge clk) begin
      if (bus.rx_valid) got_rx.push_back(bus.rx_data);
      if (bus.cmd_valid) begin
         got_cmds.push_back({bus.cmd_index, bus.cmd_arg, bus.cmd_crc_err});
         got_at.push_back(got_rx.size());
      end
      if (ready_q && !bus.tx_ready) tx_falls++;
      ready_q = bus.tx_ready;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1
   function automatic logic [6:0] crc7(input logic [39:0] m);
      logic [46:0] r = {m, 7'b0};
      for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] frame(input logic [5:0] idx, input logic [31:0] arg, input bit bad);
      logic [39:0] m = {2'b01, idx, arg};
      return {m, crc7(m), 1'b1} ^ (bad ? 48'(1) << $urandom_range(7, 0) : 48'h0);
   endfunction

   function automatic logic [7:0] junk();
      logic [7:0] b = 8'($urandom);
      if (b[7:6] == 2'b01) b[7] = 1'b1;
      return b;
   endfunction

   task automatic model(input logic [7:0] q[$]);
      int i = 0;
      logic [39:0] m;
      exp_c.delete();
      exp_at.delete();
      while (i < q.size()) begin
         if (q[i][7:6] == 2'b01 && i + 5 < q.size()) begin
            m = {q[i], q[i+1], q[i+2], q[i+3], q[i+4]};
            exp_c.push_back({q[i][5:0], m[31:0], CRC_EN && (q[i+5] != {crc7(m), 1'b1})});
            exp_at.push_back(i + 6);
            i += 6;
         end else i++;
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] mo, input logic ld, input logic [7:0] ld_data, output logic [7:0] mi);
      for (int i = 7; i >= 0; i--) begin
         bus.mosi = mo[i];
         if (ld && i == 3) begin
            bus.tx_data = ld_data;
            bus.tx_load = 1'b1;
            clks(1);
            bus.tx_load = 1'b0;
            clks(4);
         end else clks(5);
         bus.sclk = 1'b1;
         mi[i] = bus.miso;
         clks(5);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic bits(input int n);
      for (int i = 0; i < n; i++) begin
         bus.mosi = 1'b1;
         clks(5);
         bus.sclk = 1'b1;
         clks(5);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic cs_lo();
      bus._cs = 1'b0;
      clks(5);
   endtask

   task automatic cs_hi();
      clks(5);
      bus._cs = 1'b1;
      clks(8);
   endtask

   task automatic load_tx(input logic [7:0] d);
      int n = 0;
      while (!bus.tx_ready && n < 50) begin
         clks(1);
         n++;
      end
      chk("tx_ready before load", bus.tx_ready, 1);
      bus.tx_data = d;
      bus.tx_load = 1'b1;
      clks(1);
      bus.tx_load = 1'b0;
   endtask

   task automatic run_session(input logic [7:0] q[$], input string tag);
      logic [7:0] m;
      got_rx.delete();
      got_cmds.delete();
      got_at.delete();
      cs_lo();
      foreach (q[i]) xfer(q[i], 1'b0, 8'h00, m);
      cs_hi();
      model(q);
      chk({tag, " rx_count"}, got_rx.size(), q.size());
      foreach (q[i]) if (i < got_rx.size()) chk($sformatf("%s rx[%0d]", tag, i), got_rx[i], q[i]);
      chk({tag, " cmd_count"}, got_cmds.size(), exp_c.size());
      foreach (exp_c[i]) if (i < got_cmds.size()) begin
         chk($sformatf("%s cmd%0d index/arg", tag, i), got_cmds[i][38:1], exp_c[i][38:1]);
         chk($sformatf("%s cmd%0d crc_err", tag, i), got_cmds[i][0], exp_c[i][0]);
         chk($sformatf("%s cmd%0d position", tag, i), got_at[i], exp_at[i]);
      end
   endtask

   task automatic tx_session(input int n);
      logic [7:0] exp[$];
      logic [7:0] m, d;
      logic ld;
      if ($urandom_range(1, 0) == 1) begin
         d = 8'($urandom);
         load_tx(d);
         exp.push_back(d);
      end else exp.push_back(8'hFF);
      cs_lo();
      for (int k = 0; k < n; k++) begin
         ld = (k < n - 1) && ($urandom_range(1, 0) == 1);
         d = 8'($urandom);
         xfer(8'hFF, ld, d, m);
         chk($sformatf("tx_rand byte%0d", k), m, exp[k]);
         exp.push_back(ld ? d : 8'hFF);
      end
      cs_hi();
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] m0, m1, m2, m3;
      logic [47:0] f;
      int falls0;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      bus._cs = 1'b1;
      bus.tx_load = 1'b0;
      bus.tx_data = 8'h00;
      clks(2);
      repeat (3) begin
         bus.sclk = 1'b1;
         clks(2);
         bus.sclk = 1'b0;
         clks(2);
      end
      chk("reset miso", bus.miso, 1);
      chk("reset miso_oe", bus.miso_oe, 0);
      chk("reset tx_ready", bus.tx_ready, 1);
      chk("reset rx_data", bus.rx_data, 0);
      chk("reset cmd_index/arg", {bus.cmd_index, bus.cmd_arg}, 0);
      chk("reset cmd_valid/crc_err", {bus.cmd_valid, bus.cmd_crc_err}, 0);
      chk("reset rx pulses", got_rx.size(), 0);
      reset = 1'b0;
      clks(4);

      q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_session(q, "cmd0");
      q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};
      run_session(q, "cmd8");
      chk("cmd8 explicit", got_cmds.size() > 0 ? got_cmds[0] : 39'h0, {6'd8, 32'h000001AA, 1'b0});
      q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h86};
      run_session(q, "cmd8 bad");
      chk("cmd8 bad crc_err", got_cmds.size() > 0 ? got_cmds[0][0] : 1'bx, CRC_EN);

      falls0 = tx_falls;
      load_tx(8'hDE);
      cs_lo();
      chk("miso_oe active", bus.miso_oe, 1);
      xfer(8'hFF, 1'b1, 8'hAD, m0);
      xfer(8'hFF, 1'b1, 8'hBE, m1);
      xfer(8'hFF, 1'b0, 8'h00, m2);
      xfer(8'hFF, 1'b0, 8'h00, m3);
      cs_hi();
      chk("tx stream", {m0, m1, m2, m3}, 32'hDEADBEFF);
      chk("tx_ready falls", tx_falls - falls0, 3);
      chk("tx_ready after drain", bus.tx_ready, 1);
      chk("miso_oe idle", bus.miso_oe, 0);

      got_rx.delete();
      got_cmds.delete();
      cs_lo();
      xfer(8'h40, 1'b0, 8'h00, m0);
      xfer(8'h00, 1'b0, 8'h00, m0);
      xfer(8'h00, 1'b0, 8'h00, m0);
      bits(3);
      cs_hi();
      chk("abort rx_count", got_rx.size(), 3);
      chk("abort cmd_count", got_cmds.size(), 0);
      q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_session(q, "after abort");

      q = '{8'hFF, 8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_session(q, "lead ff");

      for (int s = 0; s < 5; s++) begin
         q.delete();
         repeat ($urandom_range(4, 2)) begin
            repeat ($urandom_range(2, 0)) q.push_back(junk());
            f = frame(6'($urandom), $urandom, $urandom_range(2, 0) == 0);
            for (int b = 5; b >= 0; b--) q.push_back(f[b*8 +: 8]);
         end
         if (s == 4) for (int b = 5; b >= 3; b--) q.push_back(f[b*8 +: 8]);
         run_session(q, $sformatf("rand%0d", s));
      end

      for (int s = 0; s < 4; s++) tx_session(6);

      load_tx(8'h5A);
      cs_lo();
      xfer(8'h48, 1'b0, 8'h00, m0);
      bits(4);
      #2 reset = 1'b1;
      #1;
      chk("async reset miso", bus.miso, 1);
      chk("async reset miso_oe", bus.miso_oe, 0);
      chk("async reset tx_ready", bus.tx_ready, 1);
      chk("async reset rx_data", bus.rx_data, 0);
      chk("async reset cmd", {bus.cmd_index, bus.cmd_arg, bus.cmd_valid}, 0);
      bus._cs = 1'b1;
      clks(3);
      reset = 1'b0;
      clks(4);
      q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
      run_session(q, "after reset");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
